hs_deserializer: RTL and testbench
==================================

# hs_deserializer

Reader-side consumer of a ready/valid word stream, typically placed directly behind an `hs_fifo` output. It collects `COUNT` consecutive `WIDTH`-bit beats and presents them as one `COUNT*WIDTH`-bit vector on its own ready/valid output port. Typical use: assembling a row of weights or activations for a systolic array row load.

## Interface
- `WIDTH`, 8: bits per input beat.
- `COUNT`, 4: beats per output vector; must be ≥1.
- `clk_core`  in  1  core clock, all logic on rising edge.
- `rst_core_n`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous abort of the partial vector and pending output.
- `ready_o`  out  1  block accepts a beat this cycle.
- `valid_i`  in  1  upstream beat valid.
- `in`  in  WIDTH  upstream beat data.
- `ready_i`  in  1  downstream accepts the vector.
- `valid_o`  out  1  output vector valid.
- `out`  out  COUNT*WIDTH  assembled vector; beat k occupies bits `[k*WIDTH +: WIDTH]`.
- Only with `HS_DESER_REREAD_EN`: `loop_i`  in  1  request an upstream replay after this vector.
- Only with `HS_DESER_REREAD_EN`: `reread_o`  out  1  one-cycle replay pulse to the upstream FIFO `reread`.

## Operation
- Beat handshake: `valid_i & ready_o`. Vector handshake: `valid_o & ready_i`.
- State `FILL`:
  - `ready_o=1`, `valid_o=0`.
  - Each accepted beat is written into slot `idx`, then `idx` increments.
  - Acceptance at `idx==COUNT-1` sets `idx=0` and moves to `HOLD`.
- State `HOLD`:
  - `valid_o=1`; `out` is held stable.
  - `ready_o = ready_i` (combinational path), so a beat may be accepted in the same cycle the vector is consumed.
  - On a vector handshake with no beat: go to `FILL`.
  - On a vector handshake with a beat: the beat goes to slot 0, `idx=1`, go to `FILL`.
  - Case `COUNT==1`: a vector handshake with a beat stays in `HOLD` with the new data.
- Slots are not cleared between vectors; every slot is overwritten before the next `valid_o`.
- `idx` width is `max(1,$clog2(COUNT))`; it never exceeds `COUNT-1`.
- `flush` has highest priority:
  - Next state `FILL`, `idx=0`, `valid_o=0`.
  - A beat offered in the flush cycle is dropped.
  - The data register keeps its old contents.
- Reset values: `valid_o=0`, `out=0`, `idx=0`, state `FILL`. `ready_o` is 1 immediately after reset deasserts. `reread_o=0`.
- Reset mid-vector discards all partial data.

## Timing
- Latency: `valid_o` rises the cycle after the `COUNT`th beat handshake.
- Sustained throughput: one vector per `COUNT` cycles while `valid_i` and `ready_i` stay high.
- Back-pressure: `ready_i=0` in `HOLD` holds `ready_o=0`; no beat is lost or overwritten.
- `valid_o` never drops without a handshake, except on `flush` or reset.

## Configuration
- `HS_DESER_REREAD_EN` defined:
  - If `loop_i=1` during the vector handshake, `ready_o` is forced to 0 in that cycle.
  - The block then enters state `REREAD` for one cycle: `reread_o=1`, `ready_o=0`.
  - It then proceeds to `FILL` with `idx=0`.
  - `flush` overrides `REREAD`, and `reread_o` is not asserted.
- Macro undefined: `loop_i`, `reread_o` and `REREAD` do not exist; behaviour is exactly as above.

## Structure
- Shared package `hs_pkg` holds the state enum typedef `hs_deser_state_t` (`FILL`, `HOLD`, `REREAD`).
- Single flat module; no sub-module.

## Test plan
- Setup `WIDTH=8`, `COUNT=4`; send `0x11,0x22,0x33,0x44` back-to-back with `ready_i=1` → `out=0x44332211`, `valid_o` high for one cycle, one cycle after the 4th beat.
- Setup `COUNT=4`, continuous stream `0x01..0x08` with `ready_i=1` → vectors `0x04030201` and `0x08070605`, 4 cycles apart, no bubbles.
- Hold `ready_i=0` for 5 cycles in `HOLD` → `ready_o=0`, `out` stable; on release the next vector is intact.
- `flush` after 2 beats, then send `0xA0..0xA3` → `out=0xA3A2A1A0`; the pre-flush beats are absent.
- Setup `COUNT=1`, `ready_i=1`, stream `0x05,0x06` → `valid_o` stays high; `out` shows `0x05` then `0x06` on consecutive cycles.
- With `HS_DESER_REREAD_EN`, `loop_i=1` at the vector handshake → `ready_o=0` for 2 cycles, `reread_o` pulses exactly once, in the second cycle.

Source files
------------

// File: rtl/hs_pkg.sv
// Shared handshake-block package: state encoding for the stream deserializer.
package hs_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        HOLD   = 2'd1,
        REREAD = 2'd2
    } hs_deser_state_t;

endpackage

// File: rtl/hs_deserializer.sv
// Collects COUNT ready/valid beats of WIDTH bits into one vector on a ready/valid output port.
// Optional upstream replay request (loop_i/reread_o) is built when HS_DESER_REREAD_EN is defined.
module hs_deserializer
    import hs_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int COUNT = 4
) (
    input  logic                   clk_core,
    input  logic                   rst_core_n,
    input  logic                   flush,
    output logic                   ready_o,
    input  logic                   valid_i,
    input  logic [WIDTH-1:0]       in,
    input  logic                   ready_i,
    output logic                   valid_o,
    output logic [COUNT*WIDTH-1:0] out
`ifdef HS_DESER_REREAD_EN
    ,
    input  logic                   loop_i,
    output logic                   reread_o
`endif
);

    localparam int IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(COUNT - 1);

    hs_deser_state_t        state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [COUNT*WIDTH-1:0] data_q;
    logic                   wr_en;
    logic                   beat_hs;
    logic                   vec_hs;
    logic                   loop_req;

`ifdef HS_DESER_REREAD_EN
    assign loop_req = loop_i;
`else
    assign loop_req = 1'b0;
`endif

    assign beat_hs = valid_i & ready_o;
    assign vec_hs  = valid_o & ready_i;
    assign out     = data_q;

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state_q <= FILL;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // idx is always 0 in HOLD, so a beat taken alongside a vector handshake lands in slot 0.
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            data_q <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < COUNT; k++) begin
                if (idx_q == IDX_W'(k)) begin
                    data_q[k*WIDTH +: WIDTH] <= in;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wr_en   = 1'b0;
        if (flush) begin
            state_d = FILL;
            idx_d   = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (beat_hs) begin
                        wr_en = 1'b1;
                        if (idx_q == IDX_LAST) begin
                            idx_d   = '0;
                            state_d = HOLD;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (vec_hs) begin
                        if (loop_req) begin
                            state_d = REREAD;
                            idx_d   = '0;
                        end else if (beat_hs) begin
                            wr_en = 1'b1;
                            if (COUNT == 1) begin
                                state_d = HOLD;
                                idx_d   = '0;
                            end else begin
                                state_d = FILL;
                                idx_d   = IDX_W'(1);
                            end
                        end else begin
                            state_d = FILL;
                            idx_d   = '0;
                        end
                    end
                end
                REREAD: begin
                    state_d = FILL;
                    idx_d   = '0;
                end
                default: begin
                    state_d = FILL;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // ready_o follows ready_i in HOLD so a new beat can ride along with the vector handshake.
    always_comb begin
        ready_o = 1'b0;
        valid_o = 1'b0;
`ifdef HS_DESER_REREAD_EN
        reread_o = 1'b0;
`endif
        case (state_q)
            FILL: begin
                ready_o = 1'b1;
            end
            HOLD: begin
                valid_o = 1'b1;
                ready_o = ready_i & ~loop_req;
            end
            REREAD: begin
`ifdef HS_DESER_REREAD_EN
                reread_o = ~flush;
`endif
            end
            default: begin
                ready_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_hs_deserializer.sv
// Directed bench for hs_deserializer: COUNT=4 instance plus a COUNT=1 instance.
// Replay checks are included when HS_DESER_REREAD_EN is defined.
module tb_hs_deserializer;

    logic        clk_core = 1'b0;
    logic        rst_core_n = 1'b0;

    logic        flush = 1'b0;
    logic        valid_i = 1'b0;
    logic [7:0]  in_data = '0;
    logic        ready_i = 1'b0;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] out_data;

    logic        c1_flush = 1'b0;
    logic        c1_valid_i = 1'b0;
    logic [7:0]  c1_in = '0;
    logic        c1_ready_i = 1'b0;
    logic        c1_ready_o;
    logic        c1_valid_o;
    logic [7:0]  c1_out;

`ifdef HS_DESER_REREAD_EN
    logic        loop_i = 1'b0;
    logic        reread_o;
    logic        c1_reread_o;
`endif

    int error_count = 0;
    int check_count = 0;

    always #5 clk_core = ~clk_core;

    hs_deserializer #(.WIDTH(8), .COUNT(4)) dut (
        .clk_core   (clk_core),
        .rst_core_n (rst_core_n),
        .flush      (flush),
        .ready_o    (ready_o),
        .valid_i    (valid_i),
        .in         (in_data),
        .ready_i    (ready_i),
        .valid_o    (valid_o),
        .out        (out_data)
`ifdef HS_DESER_REREAD_EN
        ,
        .loop_i     (loop_i),
        .reread_o   (reread_o)
`endif
    );

    hs_deserializer #(.WIDTH(8), .COUNT(1)) dut1 (
        .clk_core   (clk_core),
        .rst_core_n (rst_core_n),
        .flush      (c1_flush),
        .ready_o    (c1_ready_o),
        .valid_i    (c1_valid_i),
        .in         (c1_in),
        .ready_i    (c1_ready_i),
        .valid_o    (c1_valid_o),
        .out        (c1_out)
`ifdef HS_DESER_REREAD_EN
        ,
        .loop_i     (1'b0),
        .reread_o   (c1_reread_o)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r, input logic f);
        valid_i = v;
        in_data = d;
        ready_i = r;
        flush   = f;
        #1;
    endtask

    task automatic cycle();
        @(posedge clk_core);
        #1;
    endtask

    task automatic fillVector(input logic [31:0] vec);
        for (int b = 0; b < 4; b++) begin
            applyStimulus(1'b1, vec[b*8 +: 8], 1'b1, 1'b0);
            checkOutput("fill_ready", {31'd0, ready_o}, 32'd1);
            cycle();
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] stream [8];
        stream = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};

        rst_core_n = 1'b0;
        repeat (2) @(posedge clk_core);
        #1;
        rst_core_n = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("rst_ready", {31'd0, ready_o}, 32'd1);
        checkOutput("rst_valid", {31'd0, valid_o}, 32'd0);
        checkOutput("rst_out", out_data, 32'h0);
        checkOutput("rst_c1_valid", {31'd0, c1_valid_o}, 32'd0);
        checkOutput("rst_c1_out", {24'd0, c1_out}, 32'h0);
`ifdef HS_DESER_REREAD_EN
        checkOutput("rst_reread", {31'd0, reread_o}, 32'd0);
`endif

        $display("[TB] basic vector");
        for (int b = 0; b < 4; b++) begin
            applyStimulus(1'b1, 8'h11 * (b + 1), 1'b1, 1'b0);
            checkOutput("basic_valid_low", {31'd0, valid_o}, 32'd0);
            cycle();
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("basic_valid", {31'd0, valid_o}, 32'd1);
        checkOutput("basic_out", out_data, 32'h44332211);
        cycle();
        checkOutput("basic_valid_drop", {31'd0, valid_o}, 32'd0);

        $display("[TB] continuous stream");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, stream[i], 1'b1, 1'b0);
            checkOutput("stream_ready", {31'd0, ready_o}, 32'd1);
            checkOutput("stream_valid", {31'd0, valid_o}, (i == 4) ? 32'd1 : 32'd0);
            if (i == 4) checkOutput("stream_vec0", out_data, 32'h04030201);
            cycle();
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("stream_valid1", {31'd0, valid_o}, 32'd1);
        checkOutput("stream_vec1", out_data, 32'h08070605);
        cycle();

        $display("[TB] back-pressure");
        fillVector(32'h34333231);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
            checkOutput("bp_ready_low", {31'd0, ready_o}, 32'd0);
            checkOutput("bp_valid", {31'd0, valid_o}, 32'd1);
            checkOutput("bp_out_stable", out_data, 32'h34333231);
            cycle();
        end
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
        checkOutput("bp_release_ready", {31'd0, ready_o}, 32'd1);
        checkOutput("bp_release_out", out_data, 32'h34333231);
        cycle();
        for (int b = 0; b < 3; b++) begin
            applyStimulus(1'b1, 8'h56 + 8'(b), 1'b1, 1'b0);
            checkOutput("bp_next_valid_low", {31'd0, valid_o}, 32'd0);
            cycle();
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("bp_next_valid", {31'd0, valid_o}, 32'd1);
        checkOutput("bp_next_out", out_data, 32'h58575655);
        cycle();

        $display("[TB] flush mid-fill");
        applyStimulus(1'b1, 8'h91, 1'b1, 1'b0);
        cycle();
        applyStimulus(1'b1, 8'h92, 1'b1, 1'b0);
        cycle();
        applyStimulus(1'b1, 8'h93, 1'b1, 1'b1);
        cycle();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("flush_valid", {31'd0, valid_o}, 32'd0);
        fillVector(32'hA3A2A1A0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("flush_after_valid", {31'd0, valid_o}, 32'd1);
        checkOutput("flush_after_out", out_data, 32'hA3A2A1A0);
        cycle();

        $display("[TB] flush in hold");
        fillVector(32'hE4E3E2E1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("hflush_valid_before", {31'd0, valid_o}, 32'd1);
        cycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("hflush_valid", {31'd0, valid_o}, 32'd0);
        checkOutput("hflush_ready", {31'd0, ready_o}, 32'd1);
        checkOutput("hflush_data_kept", out_data, 32'hE4E3E2E1);

        $display("[TB] reset mid-vector");
        applyStimulus(1'b1, 8'h71, 1'b1, 1'b0);
        cycle();
        applyStimulus(1'b1, 8'h72, 1'b1, 1'b0);
        cycle();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        rst_core_n = 1'b0;
        #1;
        checkOutput("mrst_out", out_data, 32'h0);
        cycle();
        rst_core_n = 1'b1;
        #1;
        checkOutput("mrst_valid", {31'd0, valid_o}, 32'd0);
        checkOutput("mrst_ready", {31'd0, ready_o}, 32'd1);
        fillVector(32'h84838281);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("mrst_out_new", out_data, 32'h84838281);
        cycle();

        $display("[TB] COUNT=1");
        c1_ready_i = 1'b1;
        c1_valid_i = 1'b1;
        c1_in = 8'h05;
        #1;
        checkOutput("c1_valid_low", {31'd0, c1_valid_o}, 32'd0);
        cycle();
        c1_in = 8'h06;
        #1;
        checkOutput("c1_valid_a", {31'd0, c1_valid_o}, 32'd1);
        checkOutput("c1_ready_a", {31'd0, c1_ready_o}, 32'd1);
        checkOutput("c1_out_a", {24'd0, c1_out}, 32'h05);
        cycle();
        c1_valid_i = 1'b0;
        #1;
        checkOutput("c1_valid_b", {31'd0, c1_valid_o}, 32'd1);
        checkOutput("c1_out_b", {24'd0, c1_out}, 32'h06);
        cycle();
        checkOutput("c1_valid_end", {31'd0, c1_valid_o}, 32'd0);
        c1_ready_i = 1'b0;

`ifdef HS_DESER_REREAD_EN
        $display("[TB] replay request");
        fillVector(32'hC4C3C2C1);
        loop_i = 1'b1;
        applyStimulus(1'b1, 8'hD0, 1'b1, 1'b0);
        checkOutput("rr_hs_ready", {31'd0, ready_o}, 32'd0);
        checkOutput("rr_hs_valid", {31'd0, valid_o}, 32'd1);
        checkOutput("rr_hs_pulse", {31'd0, reread_o}, 32'd0);
        cycle();
        loop_i = 1'b0;
        applyStimulus(1'b1, 8'hD0, 1'b1, 1'b0);
        checkOutput("rr_ready", {31'd0, ready_o}, 32'd0);
        checkOutput("rr_valid", {31'd0, valid_o}, 32'd0);
        checkOutput("rr_pulse", {31'd0, reread_o}, 32'd1);
        cycle();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("rr_after_ready", {31'd0, ready_o}, 32'd1);
        checkOutput("rr_after_pulse", {31'd0, reread_o}, 32'd0);
        fillVector(32'hD3D2D1D0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("rr_next_out", out_data, 32'hD3D2D1D0);
        cycle();

        fillVector(32'hF4F3F2F1);
        loop_i = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        cycle();
        loop_i = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("rr_flush_pulse", {31'd0, reread_o}, 32'd0);
        checkOutput("rr_flush_ready", {31'd0, ready_o}, 32'd1);
        checkOutput("rr_flush_valid", {31'd0, valid_o}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
